uart_vend_controller: RTL and testbench
=======================================

Name: uart_vend_controller

Overview:
- Vending-session controller fed by the UART receive path.
- Consumes one-cycle byte strobes (rx_valid/rx_data) from a UART byte receiver and interprets ASCII keys as coin, select and stop commands.
- Sequences credit accumulation, item dispense, change/refund and inactivity timeout.
- Drives held-level vend/refund outputs that go to the LEDs / seven-segment display layer.

Parameters:
- CLK_FREQ, 100_000_000, system clock frequency in Hz
- HOLD_SEC, 1, seconds the vend/refund outputs stay high
- TIMEOUT_SEC, 10, inactivity seconds in CREDIT before automatic refund
- PRICE_A, 5, credit units for item A
- PRICE_B, 10, credit units for item B
- MAX_CREDIT, 99, saturation limit of credit

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous, active-low reset
- rx_valid  in  1  one-cycle strobe; rx_data is valid on this cycle
- rx_data  in  8  received byte
- credit  out  8  current accumulated credit
- vend_a  out  1  item A dispense level
- vend_b  out  1  item B dispense level
- refund  out  1  refund/change level
- refund_amount  out  8  units returned; stable while refund is high
- busy  out  1  high in DISPENSE or REFUND
- err  out  1  one-cycle pulse on a rejected byte

Behaviour:
- Key map:
  - '1' (8'h31): coin +1
  - '5' (8'h35): coin +5
  - 'a' (8'h61): select item A
  - 'b' (8'h62): select item B
  - 's' (8'h73): stop
  - Any other byte is rejected.
- Reset (async, reset_n=0): state IDLE; all outputs 0; timers cleared; no refund is emitted for credit held at reset.
- Latency: rx_valid in cycle N → state, credit and outputs updated at the clock edge ending cycle N, visible in cycle N+1. err pulses in cycle N+1 only.
- IDLE (credit=0):
  - Coin → credit=value, go to CREDIT.
  - Select → err; stay in IDLE.
  - 's' → ignored, no err.
  - Unknown byte → err.
- CREDIT:
  - Coin: if credit+value ≤ MAX_CREDIT, add it; otherwise err and credit unchanged (98 + '5' → err, stays 98).
  - Select X with credit ≥ PRICE_X:
    - Latch change = credit − PRICE_X (8-bit, never negative).
    - credit ← 0; vend_X ← 1; load hold timer; go to DISPENSE.
  - Select X with credit < PRICE_X → err; stay.
  - 's' → refund_amount ← credit, credit ← 0, refund ← 1, load hold timer, go to REFUND.
  - Unknown byte → err.
  - Any accepted or rejected byte reloads the inactivity timer to CLK_FREQ*TIMEOUT_SEC − 1.
  - Timer reaching 0 with no byte that cycle → treated exactly as 's'.
  - Byte and timer expiry in the same cycle → the byte wins and the timer reloads.
- DISPENSE:
  - vend_X is held for exactly CLK_FREQ*HOLD_SEC cycles.
  - On expiry: vend_X ← 0. If change > 0: refund_amount ← change, refund ← 1, reload the hold timer, go to REFUND. If change = 0: go to IDLE.
- REFUND: refund is held for CLK_FREQ*HOLD_SEC cycles. On expiry: refund ← 0, refund_amount ← 0, go to IDLE.
- DISPENSE/REFUND: every rx byte is dropped silently (no err, no credit change). busy=1.
- At most one of vend_a, vend_b, refund is high in any cycle.
- Timers are 32-bit down-counters; a hold of exactly 1 cycle (CLK_FREQ*HOLD_SEC=1) must work.

Decomposition:
- Package vend_pkg:
  - State enum: IDLE, CREDIT, DISPENSE, REFUND (2-bit).
  - Key constants KEY_COIN1, KEY_COIN5, KEY_SEL_A, KEY_SEL_B, KEY_STOP.
  - Credit width constant (8).
- Sub-module vend_timer:
  - Loadable 32-bit down-counter with a load value, a load strobe and a one-cycle expired pulse.
  - Instantiated twice: inactivity timer and hold timer.

Test Plan (CLK_FREQ=100, HOLD_SEC=1 → 100 cycles, TIMEOUT_SEC=10 → 1000 cycles):
- '5','5','a' → credit 5 then 10; vend_a high for 100 cycles; then refund high for 100 cycles with refund_amount=5; then IDLE, credit=0.
- '5','5','b' → vend_b high for 100 cycles; no refund; IDLE; credit=0; busy low after 100 cycles.
- '1','a' → err pulse, credit stays 1; then 's' → refund_amount=1 for 100 cycles.
- '5' then idle → refund rises exactly 1000 cycles after the byte cycle; refund_amount=5. A repeat run with '1' arriving on the expiry cycle → credit=6, no refund.
- Credit 98, '5' → err, credit 98. 'x' → err. 's' in IDLE → no err, no change.
- During vend_a high: '5' and reset_n pulse low → all outputs 0 immediately (async); state IDLE; no refund after release.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared types and key codes for the UART-driven vending controller.
package vend_pkg;

  localparam int CREDIT_W = 8;
  typedef logic [CREDIT_W-1:0] credit_t;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CREDIT   = 2'd1,
    DISPENSE = 2'd2,
    REFUND   = 2'd3
  } state_t;

  localparam logic [7:0] KEY_COIN1 = 8'h31;
  localparam logic [7:0] KEY_COIN5 = 8'h35;
  localparam logic [7:0] KEY_SEL_A = 8'h61;
  localparam logic [7:0] KEY_SEL_B = 8'h62;
  localparam logic [7:0] KEY_STOP  = 8'h73;

  // Coin denomination for a key byte, zero for anything that is not a coin.
  function automatic credit_t coin_value(input logic [7:0] key);
    case (key)
      KEY_COIN1: return credit_t'(1);
      KEY_COIN5: return credit_t'(5);
      default:   return '0;
    endcase
  endfunction

endpackage

// File: rtl/uart_vend_controller_if.sv
// Byte strobe input and vend/refund status bundle of the vending controller.
interface uart_vend_controller_if;
  import vend_pkg::*;

  // rx_valid is a one-cycle strobe qualifying rx_data; there is no ready/back-pressure,
  // the controller consumes (or silently drops) every strobed byte in the cycle it appears.
  logic     rx_valid;
  logic [7:0] rx_data;
  credit_t  credit;
  logic     vend_a;
  logic     vend_b;
  logic     refund;
  credit_t  refund_amount;
  logic     busy;
  logic     err;
  state_t   state;

  modport master (
    output rx_valid, rx_data,
    input  credit, vend_a, vend_b, refund, refund_amount, busy, err, state
  );

  modport slave (
    input  rx_valid, rx_data,
    output credit, vend_a, vend_b, refund, refund_amount, busy, err, state
  );

endinterface

// File: rtl/vend_timer.sv
// Loadable 32-bit down-counter; expired pulses for one cycle when a loaded count reaches zero.
module vend_timer (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        load,
  input  logic [31:0] load_val,
  output logic        expired
);

  logic [31:0] count;
  logic        running;

  // A load of N makes expired fire N+1 cycles after the load cycle.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count   <= '0;
      running <= 1'b0;
    end else if (load) begin
      count   <= load_val;
      running <= 1'b1;
    end else if (running) begin
      if (count == 32'd0) running <= 1'b0;
      else                count   <= count - 32'd1;
    end
  end

  assign expired = running && (count == 32'd0);

endmodule

// File: rtl/uart_vend_controller.sv
// Vending session FSM: credit accumulation, dispense, change/refund and inactivity timeout.
module uart_vend_controller
  import vend_pkg::*;
#(
  parameter int CLK_FREQ    = 100_000_000,
  parameter int HOLD_SEC    = 1,
  parameter int TIMEOUT_SEC = 10,
  parameter int PRICE_A     = 5,
  parameter int PRICE_B     = 10,
  parameter int MAX_CREDIT  = 99
) (
  input logic clk,
  input logic reset_n,
  uart_vend_controller_if.slave bus
);

  localparam logic [31:0] HOLD_LOAD = 32'(longint'(CLK_FREQ) * HOLD_SEC - 1);
  localparam logic [31:0] IDLE_LOAD = 32'(longint'(CLK_FREQ) * TIMEOUT_SEC - 1);
  localparam credit_t       PRICE_A_C = credit_t'(PRICE_A);
  localparam credit_t       PRICE_B_C = credit_t'(PRICE_B);
  localparam logic [CREDIT_W:0] MAX_C = (CREDIT_W+1)'(MAX_CREDIT);

  state_t  state, state_nxt;
  credit_t credit_q, credit_nxt;
  credit_t change_q, change_nxt;
  credit_t amount_q, amount_nxt;
  logic    vend_a_q, vend_a_nxt;
  logic    vend_b_q, vend_b_nxt;
  logic    refund_q, refund_nxt;
  logic    err_q, err_nxt;
  logic    idle_load, hold_load, idle_exp, hold_exp;

  logic              is_coin, is_sel, is_sel_a, stop_req;
  credit_t           price;
  logic [CREDIT_W:0] coin_sum;

  assign is_coin  = (bus.rx_data == KEY_COIN1) || (bus.rx_data == KEY_COIN5);
  assign is_sel_a = (bus.rx_data == KEY_SEL_A);
  assign is_sel   = is_sel_a || (bus.rx_data == KEY_SEL_B);
  assign price    = is_sel_a ? PRICE_A_C : PRICE_B_C;
  assign coin_sum = {1'b0, credit_q} + {1'b0, coin_value(bus.rx_data)};
  // A byte arriving on the expiry cycle wins over the timeout.
  assign stop_req = bus.rx_valid ? (bus.rx_data == KEY_STOP) : idle_exp;

  vend_timer u_idle_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (idle_load),
    .load_val (IDLE_LOAD),
    .expired  (idle_exp)
  );

  vend_timer u_hold_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (hold_load),
    .load_val (HOLD_LOAD),
    .expired  (hold_exp)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      credit_q <= '0;
      change_q <= '0;
      amount_q <= '0;
      vend_a_q <= 1'b0;
      vend_b_q <= 1'b0;
      refund_q <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_nxt;
      credit_q <= credit_nxt;
      change_q <= change_nxt;
      amount_q <= amount_nxt;
      vend_a_q <= vend_a_nxt;
      vend_b_q <= vend_b_nxt;
      refund_q <= refund_nxt;
      err_q    <= err_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    credit_nxt = credit_q;
    change_nxt = change_q;
    amount_nxt = amount_q;
    vend_a_nxt = vend_a_q;
    vend_b_nxt = vend_b_q;
    refund_nxt = refund_q;
    err_nxt    = 1'b0;
    idle_load  = 1'b0;
    hold_load  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.rx_valid) begin
          idle_load = 1'b1;
          if (is_coin) begin
            credit_nxt = coin_value(bus.rx_data);
            state_nxt  = CREDIT;
          end else if (bus.rx_data != KEY_STOP) begin
            err_nxt = 1'b1;
          end
        end
      end
      CREDIT: begin
        if (bus.rx_valid) idle_load = 1'b1;
        if (stop_req) begin
          amount_nxt = credit_q;
          credit_nxt = '0;
          refund_nxt = 1'b1;
          hold_load  = 1'b1;
          state_nxt  = REFUND;
        end else if (bus.rx_valid) begin
          if (is_coin) begin
            if (coin_sum <= MAX_C) credit_nxt = coin_sum[CREDIT_W-1:0];
            else                   err_nxt    = 1'b1;
          end else if (is_sel) begin
            if (credit_q >= price) begin
              change_nxt = credit_q - price;
              credit_nxt = '0;
              vend_a_nxt = is_sel_a;
              vend_b_nxt = !is_sel_a;
              hold_load  = 1'b1;
              state_nxt  = DISPENSE;
            end else begin
              err_nxt = 1'b1;
            end
          end else begin
            err_nxt = 1'b1;
          end
        end
      end
      DISPENSE: begin
        if (hold_exp) begin
          vend_a_nxt = 1'b0;
          vend_b_nxt = 1'b0;
          if (change_q != '0) begin
            amount_nxt = change_q;
            refund_nxt = 1'b1;
            hold_load  = 1'b1;
            state_nxt  = REFUND;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      REFUND: begin
        if (hold_exp) begin
          refund_nxt = 1'b0;
          amount_nxt = '0;
          state_nxt  = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.credit        = credit_q;
  assign bus.vend_a        = vend_a_q;
  assign bus.vend_b        = vend_b_q;
  assign bus.refund        = refund_q;
  assign bus.refund_amount = amount_q;
  assign bus.err           = err_q;
  assign bus.busy          = (state == DISPENSE) || (state == REFUND);
  assign bus.state         = state;

endmodule

// File: tb/tb_uart_vend_controller.sv
// Bench for uart_vend_controller: deadline-based session model checked every cycle, plus directed literals.
module tb_uart_vend_controller;
  import vend_pkg::*;

  localparam int H = 100;   // hold cycles (CLK_FREQ=100, HOLD_SEC=1)
  localparam int T = 1000;  // inactivity cycles (TIMEOUT_SEC=10)

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  uart_vend_controller_if bus ();
  uart_vend_controller_if bus2 ();

  uart_vend_controller #(
    .CLK_FREQ(100), .HOLD_SEC(1), .TIMEOUT_SEC(10),
    .PRICE_A(5), .PRICE_B(10), .MAX_CREDIT(99)
  ) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus)
  );

  uart_vend_controller #(
    .CLK_FREQ(1), .HOLD_SEC(1), .TIMEOUT_SEC(20),
    .PRICE_A(5), .PRICE_B(10), .MAX_CREDIT(99)
  ) dut2 (
    .clk(clk), .reset_n(reset_n), .bus(bus2)
  );

  int checks = 0;
  int failures = 0;
  logic checking = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  // Session described by deadlines (cycle numbers) rather than counters; credit>0 means a session is open.
  int cyc = 0;
  int m_credit, m_change, m_amt, m_vend, m_vend_end, m_refund_end, m_last, m_coin, m_price;
  logic m_refund, m_err;

  task automatic model_stop(input int n);
    m_amt = m_credit;
    m_credit = 0;
    m_refund = 1'b1;
    m_refund_end = n + H;
  endtask

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_credit = 0; m_change = 0; m_amt = 0; m_vend = 0; m_refund = 1'b0; m_err = 1'b0;
      m_vend_end = 0; m_refund_end = 0; m_last = 0;
    end else begin
      m_err = 1'b0;
      if (m_vend != 0) begin
        if (cyc == m_vend_end) begin
          m_vend = 0;
          if (m_change > 0) begin
            m_refund = 1'b1; m_amt = m_change; m_refund_end = cyc + H;
          end
        end
      end else if (m_refund) begin
        if (cyc == m_refund_end) begin
          m_refund = 1'b0; m_amt = 0;
        end
      end else if (bus.rx_valid) begin
        m_last = cyc;
        if (bus.rx_data == 8'h31 || bus.rx_data == 8'h35) begin
          m_coin = (bus.rx_data == 8'h31) ? 1 : 5;
          if (m_credit + m_coin <= 99) m_credit = m_credit + m_coin;
          else m_err = 1'b1;
        end else if (bus.rx_data == 8'h61 || bus.rx_data == 8'h62) begin
          m_price = (bus.rx_data == 8'h61) ? 5 : 10;
          if (m_credit >= m_price) begin
            m_change = m_credit - m_price;
            m_credit = 0;
            m_vend = (bus.rx_data == 8'h61) ? 1 : 2;
            m_vend_end = cyc + H;
          end else begin
            m_err = 1'b1;
          end
        end else if (bus.rx_data == 8'h73) begin
          if (m_credit > 0) model_stop(cyc);
        end else begin
          m_err = 1'b1;
        end
      end else if (m_credit > 0 && cyc == m_last + T) begin
        model_stop(cyc);
      end
      cyc = cyc + 1;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    if (checking) begin
      chk("cmp_credit", bus.credit, m_credit);
      chk("cmp_vend_a", bus.vend_a, m_vend == 1);
      chk("cmp_vend_b", bus.vend_b, m_vend == 2);
      chk("cmp_refund", bus.refund, m_refund);
      chk("cmp_refund_amount", bus.refund_amount, m_amt);
      chk("cmp_busy", bus.busy, (m_vend != 0) || m_refund);
      chk("cmp_err", bus.err, m_err);
      chk("cmp_exclusive", 32'(bus.vend_a) + 32'(bus.vend_b) + 32'(bus.refund) <= 1, 1);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b);
    @(posedge clk); #1;
    bus.rx_valid = 1'b1; bus.rx_data = b;
    @(posedge clk); #1;
    bus.rx_valid = 1'b0;
  endtask

  task automatic send2(input logic [7:0] b);
    @(posedge clk); #1;
    bus2.rx_valid = 1'b1; bus2.rx_data = b;
    @(posedge clk); #1;
    bus2.rx_valid = 1'b0;
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0: return bus.vend_a;
      1: return bus.vend_b;
      default: return bus.refund;
    endcase
  endfunction

  task automatic count_high(input int sel, output int n);
    n = 0;
    while (sig(sel) && n < 1000) begin
      n++;
      wait_cycles(1);
    end
  endtask

  task automatic wait_idle(input int budget);
    int i = 0;
    while (bus.busy && i < budget) begin
      wait_cycles(1);
      i++;
    end
    chk("wait_idle_budget", bus.busy, 0);
  endtask

  // ---------------- stimulus ----------------
  logic [7:0] keys [6] = '{8'h31, 8'h35, 8'h35, 8'h61, 8'h62, 8'h73};

  initial begin
    int n;
    int idx;
    bus.rx_valid = 1'b0; bus.rx_data = 8'h00;
    bus2.rx_valid = 1'b0; bus2.rx_data = 8'h00;
    wait_cycles(4);
    chk("reset_credit", bus.credit, 0);
    chk("reset_outputs", {bus.vend_a, bus.vend_b, bus.refund, bus.busy, bus.err}, 0);
    chk("reset_state", bus.state, IDLE);
    reset_n = 1'b1;
    checking = 1'b1;
    wait_cycles(2);

    // one-cycle hold instance: '5','5','a' -> vend_a 1 cycle, refund 5 for 1 cycle
    send2(8'h35); send2(8'h35);
    chk("h1_credit", bus2.credit, 10);
    send2(8'h61);
    chk("h1_vend_a", bus2.vend_a, 1);
    wait_cycles(1);
    chk("h1_vend_a_off", bus2.vend_a, 0);
    chk("h1_refund", bus2.refund, 1);
    chk("h1_amount", bus2.refund_amount, 5);
    wait_cycles(1);
    chk("h1_refund_off", bus2.refund, 0);
    chk("h1_busy_off", bus2.busy, 0);

    // '5','5','a': vend_a 100 cycles, then change of 5 for 100 cycles
    send(8'h35);
    chk("t1_credit5", bus.credit, 5);
    send(8'h35);
    chk("t1_credit10", bus.credit, 10);
    send(8'h61);
    chk("t1_busy", bus.busy, 1);
    count_high(0, n);
    chk("t1_vend_a_len", n, 100);
    chk("t1_amount", bus.refund_amount, 5);
    count_high(2, n);
    chk("t1_refund_len", n, 100);
    chk("t1_idle_credit", bus.credit, 0);
    chk("t1_idle_busy", bus.busy, 0);

    // '5','5','b': vend_b 100 cycles, no change
    send(8'h35); send(8'h35); send(8'h62);
    count_high(1, n);
    chk("t2_vend_b_len", n, 100);
    chk("t2_no_refund", bus.refund, 0);
    chk("t2_busy", bus.busy, 0);

    // '1','a' rejected, then 's' refunds 1
    send(8'h31); send(8'h61);
    chk("t3_err", bus.err, 1);
    chk("t3_credit", bus.credit, 1);
    wait_cycles(1);
    chk("t3_err_pulse", bus.err, 0);
    send(8'h73);
    chk("t3_amount", bus.refund_amount, 1);
    count_high(2, n);
    chk("t3_refund_len", n, 100);

    // inactivity: refund rises on the edge 1000 cycles after the byte's edge
    send(8'h35);
    wait_cycles(T - 1);
    chk("t4_before_timeout", bus.refund, 0);
    wait_cycles(1);
    chk("t4_timeout_refund", bus.refund, 1);
    chk("t4_timeout_amount", bus.refund_amount, 5);
    wait_idle(200);

    // byte landing on the expiry cycle wins
    send(8'h35);
    wait_cycles(T - 2);
    send(8'h31);
    chk("t5_credit6", bus.credit, 6);
    chk("t5_no_refund", bus.refund, 0);
    send(8'h73);
    wait_idle(200);

    // saturation at 98, unknown byte, stop in IDLE
    for (int i = 0; i < 19; i++) send(8'h35);
    for (int i = 0; i < 3; i++) send(8'h31);
    chk("t6_credit98", bus.credit, 98);
    send(8'h35);
    chk("t6_sat_err", bus.err, 1);
    chk("t6_sat_credit", bus.credit, 98);
    send(8'h78);
    chk("t6_unknown_err", bus.err, 1);
    send(8'h73);
    chk("t6_amount98", bus.refund_amount, 98);
    wait_idle(200);
    send(8'h73);
    chk("t6_idle_stop_err", bus.err, 0);
    chk("t6_idle_stop_credit", bus.credit, 0);
    send(8'h78);
    chk("t6_idle_unknown_err", bus.err, 1);

    // async reset while vend_a high
    send(8'h35); send(8'h35); send(8'h61);
    wait_cycles(10);
    bus.rx_valid = 1'b1; bus.rx_data = 8'h35;
    reset_n = 1'b0;
    #1;
    chk("t7_async_vend_a", bus.vend_a, 0);
    chk("t7_async_busy", bus.busy, 0);
    chk("t7_async_state", bus.state, IDLE);
    wait_cycles(1);
    bus.rx_valid = 1'b0;
    wait_cycles(2);
    reset_n = 1'b1;
    wait_cycles(300);
    chk("t7_no_refund", bus.refund, 0);
    chk("t7_credit", bus.credit, 0);

    // randomized sessions
    for (int i = 0; i < 300; i++) begin
      idx = $urandom_range(0, 7);
      if (idx < 6) send(keys[idx]);
      else send(8'($urandom_range(0, 255)));
      if ($urandom_range(0, 99) < 3) wait_cycles(T + 50);
      else wait_cycles($urandom_range(0, 4));
    end
    send(8'h73);
    wait_idle(300);

    checking = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
